// File: rtl/mac_array_ctrl_pkg.sv
// mac_pkg: shared types and constants for the MAC array sequencer.
// Holds the controller state encoding, result width and the ReLU helper
// used when MAC_ARRAY_CTRL_RELU_EN is defined.
package mac_pkg;

    // Default number of cycles from the last mac_en until mac_dot is valid
    localparam int MAC_LAT_DEFAULT = 2;

    // Width of the signed dot-product result coming out of the array
    localparam int DOT_W = 16;

    // int16 lanes in one input beat (4 channels x 32 lanes)
    localparam int BEAT_LANES = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_STREAM,
        ST_DRAIN,
        ST_OUT,
        ST_FIN
    } ctrl_state_e;

    // Clamp a signed dot product at zero
    function automatic logic [DOT_W-1:0] relu(input logic [DOT_W-1:0] x);
        return x[DOT_W-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/mac_array_ctrl_if.sv
// mac_array_ctrl_if: start/config, DMA stream, BRAM read, MAC array and
// result handshake signals of the layer sequencer. The master modport is the
// controller; the slave modport is the surrounding datapath.
interface mac_array_ctrl_if
    import mac_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 10
);
    logic              start;
    logic [LEN_W-1:0]  cfg_chunks;
    logic [CNT_W-1:0]  cfg_neurons;
    logic [ADDR_W-1:0] cfg_w_base;
    logic [ADDR_W-1:0] cfg_b_base;
    logic              busy;
    logic              done;
    logic              s_valid;
    logic              s_ready;
    logic              w_rd;
    logic [ADDR_W-1:0] w_addr;
    logic              b_rd;
    logic [ADDR_W-1:0] b_addr;
    logic              mac_en;
    logic              mac_clr;
    logic [DOT_W-1:0]  mac_dot;
    logic [DOT_W-1:0]  m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        input  start, cfg_chunks, cfg_neurons, cfg_w_base, cfg_b_base,
        input  s_valid, mac_dot, m_ready,
        output busy, done, s_ready, w_rd, w_addr, b_rd, b_addr,
        output mac_en, mac_clr, m_data, m_valid
    );

    modport slave (
        output start, cfg_chunks, cfg_neurons, cfg_w_base, cfg_b_base,
        output s_valid, mac_dot, m_ready,
        input  busy, done, s_ready, w_rd, w_addr, b_rd, b_addr,
        input  mac_en, mac_clr, m_data, m_valid
    );

endinterface

// File: rtl/mac_array_ctrl_out_reg.sv
// mac_ctrl_out_reg: neuron result register with valid/ready hold.
// Optional feature macro: MAC_ARRAY_CTRL_RELU_EN clamps negative results to 0.
module mac_ctrl_out_reg
    import mac_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [DOT_W-1:0] dot_i,
    input  logic             ready_i,
    output logic [DOT_W-1:0] data_o,
    output logic             valid_o
);

    logic [DOT_W-1:0] data_q;
    logic [DOT_W-1:0] data_d;
    logic             valid_q;
    logic             valid_d;
    logic [DOT_W-1:0] result;

    // Value captured from the array, optionally rectified
    always_comb begin
`ifdef MAC_ARRAY_CTRL_RELU_EN
        result = relu(dot_i);
`else
        result = dot_i;
`endif
    end

    // Load on the last drain cycle; hold data until the downstream handshake
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = result;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Result and valid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: runs one fully-connected layer as a series of neuron dot
// products. Per neuron: clear the array and prefetch weight/bias, stream
// DMA beats into the array, wait out MAC_LAT, then hand the result out.
// Optional feature macro: MAC_ARRAY_CTRL_RELU_EN (handled in mac_ctrl_out_reg).
module mac_array_ctrl
    import mac_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 8,
    parameter int CNT_W   = 10,
    parameter int MAC_LAT = MAC_LAT_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst_n,
    mac_array_ctrl_if.master  bus
);

    localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    ctrl_state_e       state_q, state_d;
    logic [LEN_W-1:0]  chunks_q, chunks_d;
    logic [CNT_W-1:0]  neurons_q, neurons_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  neuron_cnt_q, neuron_cnt_d;
    logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_W-1:0] b_ptr_q, b_ptr_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              s_ready_q, s_ready_d;
    logic              prefetch_q, prefetch_d;

    logic              beat_hs;
    logic              last_beat;
    logic              last_neuron;
    logic              drain_last;
    logic              out_load;
    logic              out_valid;
    logic [DOT_W-1:0]  out_data;
    logic              out_hs;

    assign beat_hs     = bus.s_valid & s_ready_q;
    assign last_beat   = (beat_cnt_q + LEN_W'(1)) == chunks_q;
    assign last_neuron = (neuron_cnt_q + CNT_W'(1)) == neurons_q;
    assign drain_last  = drain_cnt_q == DRAIN_W'(MAC_LAT - 1);
    assign out_load    = (state_q == ST_DRAIN) && drain_last;
    assign out_hs      = out_valid & bus.m_ready;

    // Next-state, counter and pointer logic for the layer sequence
    always_comb begin
        state_d      = state_q;
        chunks_d     = chunks_q;
        neurons_d    = neurons_q;
        beat_cnt_d   = beat_cnt_q;
        neuron_cnt_d = neuron_cnt_q;
        w_ptr_d      = w_ptr_q;
        b_ptr_d      = b_ptr_q;
        drain_cnt_d  = drain_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    chunks_d     = bus.cfg_chunks;
                    neurons_d    = bus.cfg_neurons;
                    w_ptr_d      = bus.cfg_w_base;
                    b_ptr_d      = bus.cfg_b_base;
                    beat_cnt_d   = '0;
                    neuron_cnt_d = '0;
                    if (bus.cfg_chunks == '0 || bus.cfg_neurons == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_PREFETCH;
                    end
                end
            end
            ST_PREFETCH: begin
                w_ptr_d    = w_ptr_q + ADDR_W'(1);
                b_ptr_d    = b_ptr_q + ADDR_W'(1);
                beat_cnt_d = '0;
                state_d    = ST_STREAM;
            end
            ST_STREAM: begin
                if (beat_hs) begin
                    if (last_beat) begin
                        drain_cnt_d = '0;
                        state_d     = ST_DRAIN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                        w_ptr_d    = w_ptr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_last) begin
                    state_d = ST_OUT;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            ST_OUT: begin
                if (out_hs) begin
                    neuron_cnt_d = neuron_cnt_q + CNT_W'(1);
                    state_d      = last_neuron ? ST_FIN : ST_PREFETCH;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered status/strobe outputs decoded from the upcoming state
    always_comb begin
        busy_d     = (state_d == ST_PREFETCH) || (state_d == ST_STREAM) ||
                     (state_d == ST_DRAIN)    || (state_d == ST_OUT);
        done_d     = (state_d == ST_FIN);
        s_ready_d  = (state_d == ST_STREAM);
        prefetch_d = (state_d == ST_PREFETCH);
    end

    // State, configuration, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            chunks_q     <= '0;
            neurons_q    <= '0;
            beat_cnt_q   <= '0;
            neuron_cnt_q <= '0;
            w_ptr_q      <= '0;
            b_ptr_q      <= '0;
            drain_cnt_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            s_ready_q    <= 1'b0;
            prefetch_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            chunks_q     <= chunks_d;
            neurons_q    <= neurons_d;
            beat_cnt_q   <= beat_cnt_d;
            neuron_cnt_q <= neuron_cnt_d;
            w_ptr_q      <= w_ptr_d;
            b_ptr_q      <= b_ptr_d;
            drain_cnt_q  <= drain_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            s_ready_q    <= s_ready_d;
            prefetch_q   <= prefetch_d;
        end
    end

    mac_ctrl_out_reg u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (out_load),
        .dot_i   (bus.mac_dot),
        .ready_i (bus.m_ready),
        .data_o  (out_data),
        .valid_o (out_valid)
    );

    // The weight read for the next beat is issued in the handshake cycle so
    // the BRAM word is already valid when that beat arrives.
    assign bus.w_rd    = prefetch_q | (beat_hs & ~last_beat);
    assign bus.w_addr  = w_ptr_q;
    assign bus.b_rd    = prefetch_q;
    assign bus.b_addr  = b_ptr_q;
    assign bus.mac_clr = prefetch_q;
    assign bus.mac_en  = beat_hs;
    assign bus.s_ready = s_ready_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.m_data  = out_data;
    assign bus.m_valid = out_valid;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl: directed, table-driven bench for mac_array_ctrl with a
// MAC stub that returns a fixed dot product per neuron (base + neuron index).
module tb_mac_array_ctrl;
    import mac_pkg::*;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 8;
    localparam int CNT_W  = 10;

    typedef struct {
        logic [LEN_W-1:0]  chunks;
        logic [CNT_W-1:0]  neurons;
        logic [ADDR_W-1:0] wBase;
        logic [ADDR_W-1:0] bBase;
        logic [15:0]       dot;
        int                stallAfter;
        int                stallLen;
        int                holdLen;
        bit                busyStart;
        int                expValidLat;
        int                expDoneLat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;

    int   macEnCnt, wRdCnt, bRdCnt, clrCnt;
    logic [ADDR_W-1:0] expWaddr, expBaddr;

    mac_array_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    mac_array_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .MAC_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] expResult(input logic [15:0] dot);
`ifdef MAC_ARRAY_CTRL_RELU_EN
        return dot[15] ? 16'h0000 : dot;
`else
        return dot;
`endif
    endfunction

    // Strobe counters and address-sequence checks for BRAM reads
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mac_en)  macEnCnt++;
            if (bus.mac_clr) clrCnt++;
            if (bus.w_rd) begin
                wRdCnt++;
                checkOutput("w_addr", 32'(bus.w_addr), 32'(expWaddr));
                expWaddr = expWaddr + 1'b1;
            end
            if (bus.b_rd) begin
                bRdCnt++;
                checkOutput("b_addr", 32'(bus.b_addr), 32'(expBaddr));
                expBaddr = expBaddr + 1'b1;
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},    32'(bus.busy),    0);
        checkOutput({tag, "_done"},    32'(bus.done),    0);
        checkOutput({tag, "_s_ready"}, 32'(bus.s_ready), 0);
        checkOutput({tag, "_w_rd"},    32'(bus.w_rd),    0);
        checkOutput({tag, "_b_rd"},    32'(bus.b_rd),    0);
        checkOutput({tag, "_mac_en"},  32'(bus.mac_en),  0);
        checkOutput({tag, "_mac_clr"}, 32'(bus.mac_clr), 0);
        checkOutput({tag, "_m_valid"}, 32'(bus.m_valid), 0);
        checkOutput({tag, "_w_addr"},  32'(bus.w_addr),  0);
        checkOutput({tag, "_b_addr"},  32'(bus.b_addr),  0);
        checkOutput({tag, "_m_data"},  32'(bus.m_data),  0);
    endtask

    task automatic clearCounters(input logic [ADDR_W-1:0] w, input logic [ADDR_W-1:0] b);
        macEnCnt = 0;
        wRdCnt   = 0;
        bRdCnt   = 0;
        clrCnt   = 0;
        expWaddr = w;
        expBaddr = b;
    endtask

    task automatic applyStimulus(input vec_t v);
        int  tStart, validLat, doneLat, beats, stallDone, holdDone, nDone;
        bit  seenValid, seenDone;
        validLat  = -1;
        doneLat   = -1;
        beats     = 0;
        stallDone = 0;
        holdDone  = 0;
        nDone     = 0;
        seenValid = 0;
        seenDone  = 0;
        @(posedge clk); #1;
        clearCounters(v.wBase, v.bBase);
        bus.cfg_chunks  = v.chunks;
        bus.cfg_neurons = v.neurons;
        bus.cfg_w_base  = v.wBase;
        bus.cfg_b_base  = v.bBase;
        bus.start       = 1'b1;
        bus.s_valid     = 1'b1;
        bus.m_ready     = (v.holdLen == 0);
        bus.mac_dot     = v.dot;
        tStart = cyc;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (cyc == tStart + 1) checkOutput("busy_rise", 32'(bus.busy), 1);
            if (bus.mac_clr) begin
                beats     = 0;
                stallDone = 0;
            end
            if (bus.mac_en) beats++;
            if (bus.s_ready && !bus.s_valid) begin
                stallDone++;
                checkOutput("w_rd_in_stall", 32'(bus.w_rd), 0);
            end
            if (bus.m_valid) begin
                if (!seenValid) begin
                    seenValid = 1;
                    validLat  = cyc - tStart;
                end
                checkOutput("m_data", 32'(bus.m_data), 32'(expResult(v.dot + 16'(nDone))));
                if (bus.m_ready) nDone++;
                else             holdDone++;
            end
            if (bus.done) begin
                seenDone = 1;
                doneLat  = cyc - tStart;
                checkOutput("busy_at_done", 32'(bus.busy), 0);
                break;
            end
            @(posedge clk); #1;
            if (v.busyStart && cyc == tStart + 3) begin
                bus.start       = 1'b1;
                bus.cfg_chunks  = 8'd1;
                bus.cfg_neurons = 10'd1;
                bus.cfg_w_base  = 10'h200;
                bus.cfg_b_base  = 10'h300;
            end else begin
                bus.start = 1'b0;
            end
            bus.s_valid = !(beats == v.stallAfter && stallDone < v.stallLen);
            bus.m_ready = !(nDone == 0 && holdDone < v.holdLen);
            bus.mac_dot = v.dot + 16'(nDone);
        end
        checkOutput("done_seen",  32'(seenDone), 1);
        checkOutput("valid_lat",  32'(validLat), 32'(v.expValidLat));
        checkOutput("done_lat",   32'(doneLat),  32'(v.expDoneLat));
        checkOutput("neurons",    32'(nDone),    32'(v.neurons));
        checkOutput("mac_en_cnt", 32'(macEnCnt), 32'(int'(v.chunks) * int'(v.neurons)));
        checkOutput("w_rd_cnt",   32'(wRdCnt),   32'(int'(v.chunks) * int'(v.neurons)));
        checkOutput("mac_clr_cnt",32'(clrCnt),   32'(v.neurons));
        checkOutput("b_rd_cnt",   32'(bRdCnt),   32'(v.neurons));
        @(negedge clk);
        checkOutput("done_pulse", 32'(bus.done), 0);
        checkOutput("idle_busy",  32'(bus.busy), 0);
    endtask

    vec_t vecs[5];

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        clearCounters('0, '0);
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.cfg_chunks  = '0;
        bus.cfg_neurons = '0;
        bus.cfg_w_base  = '0;
        bus.cfg_b_base  = '0;
        bus.s_valid     = 1'b0;
        bus.m_ready     = 1'b0;
        bus.mac_dot     = '0;

        //          chunks neur  wBase    bBase    dot       stA stL hold bs  vLat dLat
        vecs[0] = '{8'd4, 10'd1, 10'h010, 10'h020, 16'h0210, 1,  0,  0,  0,  8,   9};
        vecs[1] = '{8'd3, 10'd1, 10'h080, 10'h030, 16'h1111, 1,  2,  0,  0,  9,   10};
        vecs[2] = '{8'd2, 10'd3, 10'h100, 10'h040, 16'h0500, 1,  0,  5,  1,  6,   24};
        vecs[3] = '{8'd3, 10'd2, 10'h3FE, 10'h3FF, 16'h7FF0, 1,  0,  0,  0,  7,   15};
        vecs[4] = '{8'd1, 10'd1, 10'h005, 10'h006, 16'hFF00, 1,  0,  0,  0,  5,   6};

        #3;
        checkAllZero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
        end

        // Zero-length configurations finish immediately without activity
        for (int z = 0; z < 2; z++) begin
            int tz;
            @(posedge clk); #1;
            clearCounters(10'h050, 10'h060);
            bus.cfg_chunks  = (z == 0) ? 8'd0 : 8'd4;
            bus.cfg_neurons = (z == 0) ? 10'd3 : 10'd0;
            bus.cfg_w_base  = 10'h050;
            bus.cfg_b_base  = 10'h060;
            bus.start       = 1'b1;
            tz = cyc;
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(negedge clk);
            checkOutput("zero_done_cycle", 32'(cyc - tz), 1);
            checkOutput("zero_done",       32'(bus.done), 1);
            checkOutput("zero_busy",       32'(bus.busy), 0);
            repeat (3) @(negedge clk);
            checkOutput("zero_done_low", 32'(bus.done), 0);
            checkOutput("zero_mac_en",   32'(macEnCnt), 0);
            checkOutput("zero_w_rd",     32'(wRdCnt),   0);
            checkOutput("zero_mac_clr",  32'(clrCnt),   0);
        end

        // Asynchronous reset in the middle of a stream
        begin
            bit reached;
            reached = 0;
            @(posedge clk); #1;
            clearCounters(10'h040, 10'h070);
            bus.cfg_chunks  = 8'd8;
            bus.cfg_neurons = 10'd2;
            bus.cfg_w_base  = 10'h040;
            bus.cfg_b_base  = 10'h070;
            bus.start       = 1'b1;
            bus.s_valid     = 1'b1;
            bus.m_ready     = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (macEnCnt >= 3) begin
                    reached = 1;
                    break;
                end
            end
            checkOutput("reset_reached_stream", 32'(reached), 1);
            checkOutput("reset_pre_s_ready",    32'(bus.s_ready), 1);
            #2;
            rst_n = 1'b0;
            #1;
            checkAllZero("async_reset");
            @(posedge clk); #1;
            checkAllZero("held_reset");
            @(posedge clk); #1;
            rst_n = 1'b1;
        end

        applyStimulus(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
